// File: rtl/fifo_sample_reader_if.sv
// Handshake bundle between the tracking FIFO read port, the sample reader
// and the downstream DAC serializer.
interface fifo_sample_reader_if #(
   parameter int unsigned SAMPLE_WIDTH = 24
);
   logic [7:0]              fifo_data;
   logic                    fifo_empty;
   logic                    fifo_read;
   logic [SAMPLE_WIDTH-1:0] sample;
   logic                    sample_valid;
   logic                    sample_ready;

   modport master (
      input  fifo_data, fifo_empty, sample_ready,
      output fifo_read, sample, sample_valid
   );

   modport slave (
      output fifo_data, fifo_empty, sample_ready,
      input  fifo_read, sample, sample_valid
   );
endinterface

// File: rtl/fifo_sample_reader.sv
// Pops bytes from the tracking FIFO, packs BYTES_PER_SAMPLE of them MSB first
// into a sample word and offers it downstream on a valid/ready handshake.
module fifo_sample_reader #(
   parameter int unsigned BYTES_PER_SAMPLE = 3,
   parameter int unsigned SAMPLE_WIDTH     = 24,
   parameter int unsigned COUNT_WIDTH      = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   fifo_sample_reader_if.master   bus,
   output logic [COUNT_WIDTH-1:0] bytes_read
);
   localparam int unsigned CW = $clog2(BYTES_PER_SAMPLE + 1);
   localparam logic [CW-1:0] N_BYTES   = CW'(BYTES_PER_SAMPLE);
   localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES_PER_SAMPLE - 1);

   logic [CW-1:0]           rd_cnt;
   logic [CW-1:0]           cap_cnt;
   logic                    cap_pend;
   logic                    asm_full;
   logic [SAMPLE_WIDTH-1:0] shift;
   logic [SAMPLE_WIDTH-1:0] shift_nxt;
   logic [SAMPLE_WIDTH-1:0] sample_r;
   logic                    sample_valid_r;
   logic                    capture;
   logic                    word_done;
   logic                    load_direct;
   logic                    load_held;
   logic                    load;

   generate
      if (SAMPLE_WIDTH > 8) begin : g_wide
         assign shift_nxt = {shift[SAMPLE_WIDTH-9:0], bus.fifo_data};
      end else begin : g_narrow
         assign shift_nxt = bus.fifo_data;
      end
   endgenerate

   // A word completes directly into the output register when the slot is free;
   // otherwise it parks in shift (asm_full) and reads stall on rd_cnt==N_BYTES.
   always_comb begin
      bus.fifo_read = reset && !bus.fifo_empty && !flush && (rd_cnt < N_BYTES);
      capture       = cap_pend && !flush;
      word_done     = capture && (cap_cnt == LAST_BYTE);
      load_direct   = word_done && (!sample_valid_r || bus.sample_ready);
      load_held     = asm_full && bus.sample_ready && !flush;
      load          = load_direct || load_held;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_cnt         <= '0;
         cap_cnt        <= '0;
         cap_pend       <= 1'b0;
         asm_full       <= 1'b0;
         shift          <= '0;
         sample_r       <= '0;
         sample_valid_r <= 1'b0;
         bytes_read     <= '0;
      end else begin
         cap_pend <= bus.fifo_read;
         if (capture) begin
            bytes_read <= bytes_read + COUNT_WIDTH'(1);
         end

         if (flush) begin
            rd_cnt   <= '0;
            cap_cnt  <= '0;
            shift    <= '0;
            asm_full <= 1'b0;
         end else if (load) begin
            rd_cnt   <= '0;
            cap_cnt  <= '0;
            asm_full <= 1'b0;
            if (capture) begin
               shift <= shift_nxt;
            end
         end else begin
            if (bus.fifo_read) begin
               rd_cnt <= rd_cnt + CW'(1);
            end
            if (capture) begin
               shift   <= shift_nxt;
               cap_cnt <= cap_cnt + CW'(1);
            end
            if (word_done) begin
               asm_full <= 1'b1;
            end
         end

         if (load_direct) begin
            sample_r <= shift_nxt;
         end else if (load_held) begin
            sample_r <= shift;
         end

         if (load) begin
            sample_valid_r <= 1'b1;
         end else if (sample_valid_r && bus.sample_ready) begin
            sample_valid_r <= 1'b0;
         end
      end
   end

   assign bus.sample       = sample_r;
   assign bus.sample_valid = sample_valid_r;
endmodule

// File: tb/tb_fifo_sample_reader.sv
// Directed bench for fifo_sample_reader: a cycle vector table plus hand-written
// sequences for streaming, back-pressure, underrun, reset and counter wrap.
module tb_fifo_sample_reader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        flush;
   logic [15:0] bytes_read;
   logic        flush2;
   logic [3:0]  bytes_read2;

   fifo_sample_reader_if #(.SAMPLE_WIDTH(24)) bus ();
   fifo_sample_reader_if #(.SAMPLE_WIDTH(8))  bus2 ();

   fifo_sample_reader #(
      .BYTES_PER_SAMPLE(3),
      .SAMPLE_WIDTH(24),
      .COUNT_WIDTH(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .bus(bus),
      .bytes_read(bytes_read)
   );

   fifo_sample_reader #(
      .BYTES_PER_SAMPLE(1),
      .SAMPLE_WIDTH(8),
      .COUNT_WIDTH(4)
   ) dut2 (
      .clk(clk),
      .reset(reset),
      .flush(flush2),
      .bus(bus2),
      .bytes_read(bytes_read2)
   );

   // Byte FIFO model: write at the edge, read data valid the cycle after fifo_read.
   logic [7:0] mem [256];
   logic [7:0] wr_ptr;
   logic [7:0] rd_ptr;
   logic       push_en;
   logic [7:0] push_byte;

   always @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_en) begin
            mem[wr_ptr] <= push_byte;
            wr_ptr      <= wr_ptr + 8'd1;
         end
         if (bus.fifo_read) begin
            bus.fifo_data <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 8'd1;
         end
      end
   end
   assign bus.fifo_empty = (wr_ptr == rd_ptr);

   // Second source: endless counting bytes 0,1,2,... while en2 is set.
   logic       en2;
   logic [7:0] src2;
   always @(posedge clk) begin
      if (!reset) begin
         src2 <= '0;
      end else if (bus2.fifo_read) begin
         bus2.fifo_data <= src2;
         src2           <= src2 + 8'd1;
      end
   end
   assign bus2.fifo_empty = !en2;

   int unsigned errors = 0;
   int unsigned checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b0;
      push_en = 1'b0;
      flush   = 1'b0;
      @(negedge clk);
      reset   = 1'b1;
   endtask

   typedef struct packed {
      logic        rst_n;
      logic        push;
      logic        ready;
      logic        flsh;
      logic [7:0]  data;
      logic        exp_fr;
      logic        exp_v;
      logic [23:0] exp_s;
      logic [15:0] exp_br;
   } vec_t;

   vec_t vecs [21];

   int          fr_cnt;
   int          v_cnt;
   int          n_smp;
   int          first_fr;
   int          first_v;
   int          last_v;
   int          gap_bad;
   int          stable_bad;
   logic [7:0]  b0, b1, b2;
   logic [23:0] last_s;

   initial begin
      // rst_n push ready flush data | fifo_read valid sample bytes_read
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 24'h000000, 16'd0};
      vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h34, 1'b1, 1'b0, 24'h000000, 16'd0};
      vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h56, 1'b1, 1'b0, 24'h000000, 16'd0};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000000, 16'd1};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 24'h000000, 16'd2};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 24'h123456, 16'd3};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 24'h123456, 16'd3};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 24'h000000, 16'd0};
      vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000000, 16'd0};
      vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 24'h000000, 16'd0};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 24'h000000, 16'd1};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 24'h000000, 16'd1};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0, 24'h000000, 16'd1};
      vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 24'h000000, 16'd1};
      vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 24'h000000, 16'd2};
      vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 24'h000000, 16'd3};
      vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 24'h112233, 16'd4};
      vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 24'h112233, 16'd4};
      vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 24'h112233, 16'd4};
      vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 24'h112233, 16'd4};
      vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 24'h112233, 16'd4};

      reset             = 1'b0;
      push_en           = 1'b0;
      push_byte         = '0;
      flush             = 1'b0;
      flush2            = 1'b0;
      en2               = 1'b0;
      bus.sample_ready  = 1'b0;
      bus2.sample_ready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Cycle table: preload/first sample, reset, flush realign, flush on capture.
      for (int i = 0; i < 21; i++) begin
         @(negedge clk);
         reset            = vecs[i].rst_n;
         push_en          = vecs[i].push;
         push_byte        = vecs[i].data;
         bus.sample_ready = vecs[i].ready;
         flush            = vecs[i].flsh;
         #1;
         check($sformatf("v%0d_fifo_read", i), 32'(bus.fifo_read), 32'(vecs[i].exp_fr));
         check($sformatf("v%0d_valid", i), 32'(bus.sample_valid), 32'(vecs[i].exp_v));
         check($sformatf("v%0d_sample", i), 32'(bus.sample), 32'(vecs[i].exp_s));
         check($sformatf("v%0d_bytes_read", i), 32'(bytes_read), 32'(vecs[i].exp_br));
      end

      // Stream 30 bytes 0x00..0x1D with ready held high.
      do_reset();
      bus.sample_ready = 1'b1;
      n_smp = 0; first_fr = -1; first_v = -1; last_v = -1; gap_bad = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         push_en   = (c < 30);
         push_byte = 8'(c);
         #1;
         if (bus.fifo_read && first_fr < 0) first_fr = c;
         if (bus.sample_valid) begin
            b0 = 8'(3 * n_smp);
            b1 = 8'(3 * n_smp + 1);
            b2 = 8'(3 * n_smp + 2);
            check($sformatf("stream_sample%0d", n_smp), 32'(bus.sample), 32'({b0, b1, b2}));
            if (last_v >= 0 && (c - last_v) != 4) gap_bad++;
            if (first_v < 0) first_v = c;
            last_v = c;
            n_smp++;
         end
      end
      check("stream_count", 32'(n_smp), 32'd10);
      check("stream_first_latency", 32'(first_v - first_fr), 32'd4);
      check("stream_gap_errors", 32'(gap_bad), 32'd0);
      check("stream_bytes_read", 32'(bytes_read), 32'd30);

      // Back-pressure: 6 bytes with ready low, second word parks in shift.
      do_reset();
      bus.sample_ready = 1'b0;
      fr_cnt = 0; stable_bad = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         push_en   = (c < 6);
         push_byte = 8'(c);
         #1;
         if (bus.fifo_read) fr_cnt++;
         if (bus.sample_valid && bus.sample !== 24'h000102) stable_bad++;
      end
      check("bp_read_pulses", 32'(fr_cnt), 32'd6);
      check("bp_sample_stable", 32'(stable_bad), 32'd0);
      check("bp_sample", 32'(bus.sample), 32'h000102);
      check("bp_valid", 32'(bus.sample_valid), 32'd1);
      check("bp_asm_full", 32'(dut.asm_full), 32'd1);
      check("bp_bytes_read", 32'(bytes_read), 32'd6);
      @(negedge clk);
      bus.sample_ready = 1'b1;
      @(negedge clk);
      bus.sample_ready = 1'b0;
      #1;
      check("bp_release_sample", 32'(bus.sample), 32'h030405);
      check("bp_release_valid", 32'(bus.sample_valid), 32'd1);
      check("bp_release_asm_full", 32'(dut.asm_full), 32'd0);
      @(negedge clk);
      bus.sample_ready = 1'b1;
      @(negedge clk);
      #1;
      check("bp_drain_valid", 32'(bus.sample_valid), 32'd0);
      check("bp_drain_fifo_read", 32'(bus.fifo_read), 32'd0);

      // Underrun: 0xAA 0xBB, five empty cycles, then 0xCC.
      do_reset();
      bus.sample_ready = 1'b1;
      fr_cnt = 0; v_cnt = 0; last_s = '0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         push_en   = (c == 0) || (c == 1) || (c == 7);
         push_byte = (c == 0) ? 8'hAA : (c == 1) ? 8'hBB : 8'hCC;
         #1;
         if (bus.fifo_read) fr_cnt++;
         if (bus.sample_valid) begin
            v_cnt++;
            last_s = bus.sample;
         end
      end
      check("underrun_read_pulses", 32'(fr_cnt), 32'd3);
      check("underrun_samples", 32'(v_cnt), 32'd1);
      check("underrun_sample", 32'(last_s), 32'hAABBCC);

      // Reset asserted mid-sample while the FIFO still holds data.
      @(negedge clk);
      push_en = 1'b1; push_byte = 8'h55;
      @(negedge clk);
      push_byte = 8'h66;
      @(negedge clk);
      push_en = 1'b0;
      reset   = 1'b0;
      #1;
      check("rst_fifo_read_comb", 32'(bus.fifo_read), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("rst_sample", 32'(bus.sample), 32'd0);
      check("rst_valid", 32'(bus.sample_valid), 32'd0);
      check("rst_bytes_read", 32'(bytes_read), 32'd0);
      check("rst_fifo_read", 32'(bus.fifo_read), 32'd0);
      v_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         if (bus.sample_valid) v_cnt++;
      end
      check("rst_no_spurious_valid", 32'(v_cnt), 32'd0);

      // Counter wrap on the 1-byte / 4-bit-counter instance.
      en2 = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         #1;
         if (bytes_read2 == 4'd15) break;
      end
      check("wrap_reach_max", 32'(bytes_read2), 32'd15);
      check("wrap_sample_at_max", 32'(bus2.sample), 32'h0E);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         if (bytes_read2 != 4'd15) break;
      end
      check("wrap_to_zero", 32'(bytes_read2), 32'd0);
      check("wrap_sample_after", 32'(bus2.sample), 32'h0F);
      en2 = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
